// File: rtl/uart_rx.sv
// uart_rx: oversampling UART receiver with phase-accumulator tick generation
module uart_rx #(
    parameter int CLK_FREQ   = 100_000_000,
    parameter int DATA_WIDTH = 8,
    parameter int OVERSAMPLE = 16
) (
    input  logic                  S_AXI_ACLK,
    input  logic                  S_AXI_ARESETN,
    input  logic                  UART_RX,
    input  logic [31:0]           baud_rate,
    output logic [DATA_WIDTH-1:0] rx_data,
    output logic                  rx_done,
    output logic                  rx_ready,
    output logic                  frame_error
);
    localparam int TW = OVERSAMPLE > 2 ? $clog2(OVERSAMPLE) : 1;
    localparam int BW = $clog2(DATA_WIDTH + 1);
    localparam logic [TW-1:0] T_LAST = TW'(OVERSAMPLE - 1);
    localparam logic [TW-1:0] T_HALF = TW'(OVERSAMPLE / 2 - 1);
    localparam logic [BW-1:0] B_LAST = BW'(DATA_WIDTH - 1);
    localparam logic [32:0]   CF     = 33'(CLK_FREQ);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t                state, state_next;
    logic [1:0]            sync;
    logic                  line;
    logic [63:0]           prod;
    logic [31:0]           inc_new, inc, acc;
    logic [32:0]           sum;
    logic                  tick, tick_end, tick_half;
    logic [TW-1:0]         tick_cnt;
    logic [BW-1:0]         bit_cnt;
    logic [DATA_WIDTH-1:0] shift;
    logic                  start, sample, done_set, err_set;

    assign line      = sync[1];
    assign prod      = 64'(baud_rate) * 64'(OVERSAMPLE);
    assign inc_new   = prod >= 64'(CLK_FREQ) ? CF[31:0] : prod[31:0];
    assign sum       = {1'b0, acc} + {1'b0, inc};
    assign tick      = state != IDLE && sum >= CF;
    assign tick_end  = tick && tick_cnt == T_LAST;
    assign tick_half = tick && tick_cnt == T_HALF;
    assign rx_ready  = state == IDLE;

    // Two-flop synchronizer; idles high so reset does not look like a start bit
    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) sync <= 2'b11;
        else                sync <= {sync[0], UART_RX};
    end

    // State register
    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) state <= IDLE;
        else                state <= state_next;
    end

    // Next-state and per-cycle strobes; a zero baud rate never starts a frame
    always_comb begin
        state_next = state;
        start      = 1'b0;
        sample     = 1'b0;
        done_set   = 1'b0;
        err_set    = 1'b0;
        unique case (state)
            IDLE:  if (!line && baud_rate != 32'd0) begin
                       start      = 1'b1;
                       state_next = START;
                   end
            START: if (tick_half) state_next = line ? IDLE : DATA;
            DATA:  if (tick_end) begin
                       sample     = 1'b1;
                       state_next = bit_cnt == B_LAST ? STOP : DATA;
                   end
            STOP:  if (tick_end) begin
                       done_set   = line;
                       err_set    = !line;
                       state_next = IDLE;
                   end
            default: state_next = IDLE;
        endcase
    end

    // Phase accumulator; increment frozen at start detection for the whole frame
    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            inc <= '0;
            acc <= '0;
        end else begin
            if (start) inc <= inc_new;
            acc <= state == IDLE ? '0 : tick ? 32'(sum - CF) : sum[31:0];
        end
    end

    // Tick and bit counters restart on every state change
    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            tick_cnt <= '0;
            bit_cnt  <= '0;
        end else if (state_next != state) begin
            tick_cnt <= '0;
            bit_cnt  <= '0;
        end else begin
            if (tick)   tick_cnt <= tick_end ? '0 : tick_cnt + 1'b1;
            if (sample) bit_cnt  <= bit_cnt + 1'b1;
        end
    end

    // LSB-first shift register and registered result pulses
    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            shift       <= '0;
            rx_data     <= '0;
            rx_done     <= 1'b0;
            frame_error <= 1'b0;
        end else begin
            if (sample)   shift   <= {line, shift[DATA_WIDTH-1:1]};
            if (done_set) rx_data <= shift;
            rx_done     <= done_set;
            frame_error <= err_set;
        end
    end
endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed and randomized frames checked against a frame-level model
module tb_uart_rx;
    localparam int CLK_FREQ = 1_843_200;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        rx = 1'b1;
    logic [31:0] baud = 32'd115200;
    logic [7:0]  rx_data;
    logic        rx_done, rx_ready, frame_error;

    int checks = 0, errors = 0;
    int cyc = 0;
    int done_cnt = 0, err_cnt = 0, both_cnt = 0, done_cyc = 0, err_cyc = 0;
    int exp_done = 0, exp_err = 0, start_cyc = 0;
    logic [7:0] exp_data = 8'h00;
    logic       last_stop = 1'b1;
    logic       ready_low;
    int         bauds[4] = '{115200, 57600, 38400, 19200};

    uart_rx #(.CLK_FREQ(CLK_FREQ), .DATA_WIDTH(8), .OVERSAMPLE(16)) dut (
        .S_AXI_ACLK(clk),
        .S_AXI_ARESETN(rst_n),
        .UART_RX(rx),
        .baud_rate(baud),
        .rx_data(rx_data),
        .rx_done(rx_done),
        .rx_ready(rx_ready),
        .frame_error(frame_error)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Pulse monitor, sampled away from the active edge
    always @(negedge clk) begin
        if (rx_done) begin
            done_cnt++;
            done_cyc = cyc;
        end
        if (frame_error) begin
            err_cnt++;
            err_cyc = cyc;
        end
        if (rx_done && frame_error) both_cnt++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic idle(input int n);
        rx = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    // Serial frame of bp clocks per bit; chg!=0 alters baud_rate after the start bit
    task automatic send(input logic [7:0] d, input logic stop, input int bp, input logic [31:0] chg);
        rx = 1'b0;
        start_cyc = cyc;
        repeat (bp) @(negedge clk);
        chk("ready_busy", rx_ready, 1'b0);
        if (chg != 0) baud = chg;
        for (int i = 0; i < 8; i++) begin
            rx = d[i];
            repeat (bp) @(negedge clk);
        end
        rx = stop;
        repeat (bp) @(negedge clk);
        last_stop = stop;
        if (stop) begin
            exp_done++;
            exp_data = d;
        end else exp_err++;
    endtask

    // Result pulse must land near the middle of the stop bit (9.5 bit periods in)
    task automatic check_frame(input string tag, input int bp);
        int lat = last_stop ? done_cyc - start_cyc : err_cyc - start_cyc;
        chk({tag, "_done"}, done_cnt, exp_done);
        chk({tag, "_err"}, err_cnt, exp_err);
        chk({tag, "_data"}, rx_data, exp_data);
        chk({tag, "_lat"}, lat >= bp * 19 / 2 && lat <= bp * 19 / 2 + 8, 1'b1);
    endtask

    initial begin
        repeat (5) @(negedge clk);
        chk("rst_data", rx_data, 8'h00);
        chk("rst_ready", rx_ready, 1'b1);
        chk("rst_done", rx_done, 1'b0);
        chk("rst_err", frame_error, 1'b0);
        rst_n = 1'b1;
        idle(10);
        chk("rel_data", rx_data, 8'h00);
        chk("rel_ready", rx_ready, 1'b1);
        chk("rel_pulses", done_cnt + err_cnt, 0);

        send(8'hA5, 1'b1, 16, 0);
        check_frame("a5", 16);
        idle(20);
        chk("a5_ready_after", rx_ready, 1'b1);

        rx = 1'b0;
        repeat (4) @(negedge clk);
        chk("glitch_busy", rx_ready, 1'b0);
        idle(40);
        chk("glitch_done", done_cnt, exp_done);
        chk("glitch_err", err_cnt, exp_err);
        chk("glitch_ready", rx_ready, 1'b1);

        send(8'h3C, 1'b0, 16, 0);
        check_frame("3c_err", 16);
        idle(40);
        chk("3c_ready_after", rx_ready, 1'b1);

        send(8'h00, 1'b1, 16, 0);
        check_frame("b2b_00", 16);
        send(8'hFF, 1'b1, 16, 0);
        check_frame("b2b_ff", 16);
        idle(20);

        rx = 1'b0;
        repeat (16) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            rx = i[0] ? 1'b0 : 1'b1;
            repeat (16) @(negedge clk);
        end
        rx = 1'b1;
        repeat (8) @(negedge clk);
        rst_n = 1'b0;
        exp_data = 8'h00;
        @(negedge clk);
        chk("midrst_data", rx_data, exp_data);
        chk("midrst_ready", rx_ready, 1'b1);
        repeat (4) @(negedge clk);
        rst_n = 1'b1;
        idle(200);
        chk("midrst_done", done_cnt, exp_done);
        chk("midrst_err", err_cnt, exp_err);
        send(8'h81, 1'b1, 16, 0);
        check_frame("after_rst_81", 16);
        idle(20);

        baud = 32'd57600;
        send(8'hC3, 1'b1, 32, 32'd115200);
        check_frame("baud_chg", 32);
        idle(40);

        for (int n = 0; n < 16; n++) begin
            int bp;
            logic [7:0] d;
            logic stop;
            baud = bauds[$urandom_range(0, 3)];
            bp = CLK_FREQ / int'(baud);
            d = 8'($urandom);
            stop = $urandom_range(0, 3) != 0;
            send(d, stop, bp, 0);
            check_frame("rand", bp);
            if (!stop || $urandom_range(0, 1) != 0) begin
                idle(bp + $urandom_range(0, bp));
                chk("rand_ready", rx_ready, 1'b1);
            end
        end
        idle(100);

        baud = 32'd0;
        ready_low = 1'b0;
        for (int i = 0; i < 200; i++) begin
            rx = 1'($urandom);
            @(negedge clk);
            if (!rx_ready) ready_low = 1'b1;
        end
        idle(5);
        chk("b0_ready", ready_low, 1'b0);
        chk("b0_done", done_cnt, exp_done);
        chk("b0_err", err_cnt, exp_err);
        baud = 32'd115200;
        idle(5);
        send(8'h5A, 1'b1, 16, 0);
        check_frame("b0_recover", 16);
        idle(20);

        chk("never_both", both_cnt, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
